// File: rtl/uart_pkg.sv
// Shared encodings for the UART pattern generator: operating modes and line-control bytes.
package uart_pkg;

    typedef enum logic [1:0] {
        ModeOff       = 2'd0,
        ModeSweep     = 2'd1,
        ModeEcho      = 2'd2,
        ModeSweepCrlf = 2'd3
    } mode_e;

    localparam logic [7:0] CharCr = 8'h0D;
    localparam logic [7:0] CharLf = 8'h0A;

endpackage

// File: rtl/uart_pattern_fifo.sv
// Small echo buffer: power-of-two depth, push/pop with a simultaneous push+pop allowed when full.
module uart_pattern_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push on a full buffer still lands.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AddrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AddrW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_pattern_gen.sv
// UART test-pattern source: periodic character sweep (optionally with CR/LF) or receive echo,
// handing one byte at a time to a transmitter through a write/busy handshake.
module uart_pattern_gen
    import uart_pkg::*;
#(
    parameter int unsigned TICK_PERIOD = 1200000,
    parameter int unsigned FIRST_CHAR  = 65,
    parameter int unsigned LAST_CHAR   = 90,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] mode_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_busy_i,
    output logic       tx_write_o,
    output logic [7:0] tx_data_o,
    output logic       tick_o,
    output logic       overflow_o
);

    localparam int unsigned    CntW      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CntW-1:0] CntReload = CntW'(TICK_PERIOD - 1);
    localparam logic [7:0]     FirstChar = 8'(FIRST_CHAR);
    localparam logic [7:0]     LastChar  = 8'(LAST_CHAR);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StDrain} state_e;
    typedef enum logic [1:0] {CrlfNone, CrlfCr, CrlfLf} crlf_e;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    crlf_e           crlf_q, crlf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            pending_q, pending_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      char_q, char_d;
    logic [7:0]      data_q, data_d;

    logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       mode_change, sweep, byte_avail;
    logic [7:0] sweep_byte, next_byte;

    uart_pattern_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (rx_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        cnt_d      = (cnt_q == '0) ? CntReload : cnt_q - CntW'(1);
        tick_d     = (cnt_q == '0);
        state_d    = state_q;
        mode_d     = mode_q;
        crlf_d     = crlf_q;
        pending_d  = pending_q;
        ovf_d      = ovf_q;
        char_d     = char_q;
        data_d     = data_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        mode_change = (state_q == StIdle) && (mode_i != mode_q);
        sweep       = (mode_q == ModeSweep) || (mode_q == ModeSweepCrlf);
        sweep_byte  = (crlf_q == CrlfCr) ? CharCr : (crlf_q == CrlfLf) ? CharLf : char_q;
        byte_avail  = sweep ? pending_q : ((mode_q == ModeEcho) && !fifo_empty);
        next_byte   = sweep ? sweep_byte : fifo_head;
        fifo_push   = (mode_q == ModeEcho) && rx_valid_i && !mode_change;

        unique case (state_q)
            StIdle: begin
                if (mode_change) begin
                    mode_d     = mode_e'(mode_i);
                    char_d     = FirstChar;
                    crlf_d     = CrlfNone;
                    pending_d  = 1'b0;
                    ovf_d      = 1'b0;
                    fifo_flush = 1'b1;
                end else if (byte_avail && !tx_busy_i) begin
                    state_d = StIssue;
                    data_d  = next_byte;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
                if (sweep) begin
                    pending_d = 1'b0;
                    if (crlf_q == CrlfCr) begin
                        crlf_d = CrlfLf;
                    end else if (crlf_q == CrlfLf) begin
                        crlf_d = CrlfNone;
                    end else if (char_q == LastChar) begin
                        char_d = FirstChar;
                        if (mode_q == ModeSweepCrlf) begin
                            crlf_d = CrlfCr;
                        end
                    end else begin
                        char_d = char_q + 8'd1;
                    end
                end else if (mode_q == ModeEcho) begin
                    fifo_pop = 1'b1;
                end
            end
            StWaitBusy: begin
                if (tx_busy_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!tx_busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A tick landing in the ISSUE cycle is a fresh request, so it wins over the clear.
        if (sweep && tick_q && !mode_change) begin
            pending_d = 1'b1;
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            mode_q    <= ModeOff;
            crlf_q    <= CrlfNone;
            cnt_q     <= CntReload;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            char_q    <= FirstChar;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            crlf_q    <= crlf_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            char_q    <= char_d;
            data_q    <= data_d;
        end
    end

    assign tx_write_o = (state_q == StIssue);
    assign tx_data_o  = data_q;
    assign tick_o     = tick_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: sweep vectors from a table, echo/overflow/coalesce/reset sequences.
module tb_uart_pattern_gen;

    localparam int unsigned TP = 8;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = 8'd0;
    logic       tx_busy_i = 1'b0;
    logic       tx_write_o;
    logic [7:0] tx_data_o;
    logic       tick_o;
    logic       overflow_o;

    uart_pattern_gen #(
        .TICK_PERIOD (TP),
        .FIRST_CHAR  (65),
        .LAST_CHAR   (67),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .mode_i     (mode_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .tx_busy_i  (tx_busy_i),
        .tx_write_o (tx_write_o),
        .tx_data_o  (tx_data_o),
        .tick_o     (tick_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         nticks;
        logic [7:0] exp [6];
    } vec_t;

    vec_t       vecs [2];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    int         wr_cnt = 0;
    int         busy_cnt = 0;
    bit         busy_hold = 1'b0;
    bit         wr_seen = 1'b0;
    int         cyc = 0;
    bit         started = 1'b0;
    int         base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sync_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * TP; i++) begin
            step(1);
            if (tick_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("sync_tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_writes(input string name, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_cnt >= target) break;
            step(1);
        end
        check(name, wr_cnt, target);
    endtask

    // Cycle index since reset release; tick expected after every TP-th edge.
    initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (!rst_ni) cyc = 0;
        else cyc = cyc + 1;
    end

    // Output monitor: tick cadence every cycle, and every write checked against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("tick_cadence", 32'(tick_o), 32'((cyc > 0) && (cyc % TP == 0)));
            if (tx_write_o === 1'b1) begin
                wr_cnt++;
                wr_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %0h, expected no write (t=%0t)",
                             tx_data_o, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data_o), 32'(exp_b));
                end
            end
        end
    end

    // Transmitter model: busy for 5 cycles starting the cycle after a write, plus a hold override.
    initial forever begin
        @(posedge clk);
        #2;
        if (wr_seen) begin
            busy_cnt = 5;
            wr_seen  = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy_i = busy_hold || (busy_cnt > 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0].mode   = 2'd1;
        vecs[0].nticks = 5;
        vecs[0].exp    = '{8'd65, 8'd66, 8'd67, 8'd65, 8'd66, 8'd0};
        vecs[1].mode   = 2'd3;
        vecs[1].nticks = 6;
        vecs[1].exp    = '{8'd65, 8'd66, 8'd67, 8'h0D, 8'h0A, 8'd65};

        // Reset state
        step(3);
        check("rst_write", 32'(tx_write_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_tick", 32'(tick_o), 32'd0);
        rst_ni = 1'b1;

        // OFF for 40 cycles with rx traffic: ticks only, no writes
        for (int i = 0; i < 40; i++) begin
            rx_valid_i = (i % 3 == 0);
            rx_data_i  = 8'($urandom_range(0, 255));
            step(1);
        end
        rx_valid_i = 1'b0;
        check("off_no_writes", wr_cnt, 0);

        // Sweep vectors
        for (int v = 0; v < 2; v++) begin
            sync_tick();
            mode_i = vecs[v].mode;
            base   = wr_cnt;
            for (int k = 0; k < vecs[v].nticks; k++) exp_q.push_back(vecs[v].exp[k]);
            for (int nt = 0, i = 0; i < (vecs[v].nticks + 2) * TP; i++) begin
                step(1);
                if (tick_o) nt++;
                if (nt == vecs[v].nticks) break;
            end
            wait_writes("sweep_writes", base + vecs[v].nticks, 12);
            mode_i = 2'd0;
            step(16);
            check("sweep_count", wr_cnt, base + vecs[v].nticks);
            check("sweep_queue_empty", exp_q.size(), 0);
        end

        // Echo overflow while transmitter busy
        mode_i    = 2'd2;
        busy_hold = 1'b1;
        step(2);
        check("echo_ovf_clear", 32'(overflow_o), 32'd0);
        base = wr_cnt;
        for (int i = 0; i < 4; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i  = 8'h31 + 8'(i);
            if (i < 2) exp_q.push_back(8'h31 + 8'(i));
            step(1);
        end
        rx_valid_i = 1'b0;
        check("echo_ovf_set", 32'(overflow_o), 32'd1);
        busy_hold = 1'b0;
        wait_writes("echo_ovf_writes", base + 2, 30);
        step(10);
        check("echo_ovf_sticky", 32'(overflow_o), 32'd1);
        check("echo_ovf_count", wr_cnt, base + 2);
        mode_i = 2'd0;
        step(15);
        check("echo_ovf_cleared", 32'(overflow_o), 32'd0);

        // Echo with push and pop on a full buffer in the same cycle
        mode_i = 2'd2;
        step(2);
        base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i  = 8'h50 + 8'(i);
            exp_q.push_back(8'h50 + 8'(i));
            step(1);
        end
        rx_valid_i = 1'b0;
        check("echo_full_pushpop_ovf", 32'(overflow_o), 32'd0);
        wait_writes("echo_full_pushpop_writes", base + 3, 40);
        mode_i = 2'd0;
        step(15);

        // Busy held 20 cycles: two ticks coalesce into one write
        sync_tick();
        mode_i    = 2'd1;
        busy_hold = 1'b1;
        base      = wr_cnt;
        exp_q.push_back(8'd65);
        step(20);
        check("coalesce_none_while_busy", wr_cnt, base);
        busy_hold = 1'b0;
        wait_writes("coalesce_write", base + 1, 6);
        mode_i = 2'd0;
        step(16);
        check("coalesce_single", wr_cnt, base + 1);

        // Reset during DRAIN, then sweep restarts at the first character
        sync_tick();
        mode_i = 2'd1;
        base   = wr_cnt;
        exp_q.push_back(8'd65);
        wait_writes("pre_reset_write", base + 1, 12);
        step(2);
        rst_ni = 1'b0;
        step(2);
        check("mid_rst_write", 32'(tx_write_o), 32'd0);
        check("mid_rst_data", 32'(tx_data_o), 32'd0);
        rst_ni = 1'b1;
        base   = wr_cnt;
        exp_q.push_back(8'd65);
        wait_writes("post_reset_write", base + 1, 20);
        mode_i = 2'd0;
        step(16);
        check("post_reset_count", wr_cnt, base + 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_pattern_gen.md
UART_PATTERN_GEN -- requirements
Module: uart_pattern_gen

Interface
REQ-001 The block SHALL have parameter TICK_PERIOD, default 1200000, meaning clocks per sweep tick (10 Hz at 12 MHz).
REQ-002 The block SHALL have parameter FIRST_CHAR, default 65, meaning the first sweep byte ('A').
REQ-003 The block SHALL have parameter LAST_CHAR, default 90, meaning the last sweep byte ('Z'); FIRST_CHAR <= LAST_CHAR.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning echo buffer entries (power of two, >= 2).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port mode_i, input, 2 bits: 0 OFF, 1 SWEEP, 2 ECHO, 3 SWEEP_CRLF.
REQ-008 The block SHALL have port rx_valid_i, input, 1 bit: one-cycle strobe, received byte valid.
REQ-009 The block SHALL have port rx_data_i, input, 8 bits: received byte.
REQ-010 The block SHALL have port tx_busy_i, input, 1 bit: transmitter busy; asserted from the cycle after a write until the stop bit ends.
REQ-011 The block SHALL have port tx_write_o, output, 1 bit: one-cycle write strobe to the transmitter.
REQ-012 The block SHALL have port tx_data_o, output, 8 bits: byte to send, valid while tx_write_o is high.
REQ-013 The block SHALL have port tick_o, output, 1 bit: one-cycle pulse every TICK_PERIOD clocks.
REQ-014 The block SHALL have port overflow_o, output, 1 bit: sticky echo-FIFO overflow flag.

Function
REQ-015 The tick counter SHALL count TICK_PERIOD-1 down to 0 and pulse tick_o in the 0 cycle, giving a period of exactly TICK_PERIOD in all modes.
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and DRAIN; ISSUE lasts one cycle and drives tx_write_o=1.
REQ-017 In IDLE, the FSM SHALL move to ISSUE when a byte is available and tx_busy_i=0.
REQ-018 ISSUE SHALL always go to WAIT_BUSY; WAIT_BUSY SHALL go to DRAIN on tx_busy_i=1; DRAIN SHALL go to IDLE on tx_busy_i=0.
REQ-019 In SWEEP, a tick SHALL set a single pending flag; further ticks while it is pending SHALL coalesce; ISSUE clears it.
REQ-020 In SWEEP, the sent byte SHALL be the current character, then advance by 1, wrapping from LAST_CHAR to FIRST_CHAR.
REQ-021 SWEEP_CRLF SHALL behave as SWEEP, except that after LAST_CHAR the next two ticks send 0x0D and then 0x0A before FIRST_CHAR.
REQ-022 In ECHO, each rx_valid_i SHALL push rx_data_i into the FIFO; when the FIFO is non-empty, IDLE issues the head byte and pops it in ISSUE.
REQ-023 A push when the FIFO is full SHALL drop the byte and set overflow_o; a push and a pop in the same cycle on a full FIFO SHALL both succeed.
REQ-024 In ECHO, bytes SHALL be sent in arrival order with no duplication.
REQ-025 In OFF, tx_write_o SHALL stay 0, rx bytes SHALL be ignored, and ticks SHALL NOT set the pending flag.
REQ-026 A mode_i change SHALL be applied only in IDLE; a byte in flight completes first.
REQ-027 Applying a mode change SHALL reset the current character to FIRST_CHAR, flush the FIFO, clear the pending and CR/LF flags, and clear overflow_o.
REQ-028 tx_data_o SHALL be registered and held stable from ISSUE until the next ISSUE.

Reset
REQ-029 While rst_ni=0 at a clk_i edge, the block SHALL enter IDLE and force tx_write_o=0, tick_o=0, overflow_o=0, tx_data_o=0.
REQ-030 Reset SHALL empty the FIFO, clear the pending flag, set the current character to FIRST_CHAR, and load the tick counter with TICK_PERIOD-1.
REQ-031 Reset asserted mid-byte SHALL abort the FSM immediately; the first tick after release SHALL occur TICK_PERIOD cycles after reset deasserts.

Structure
REQ-032 The mode encodings and the CR (0x0D) and LF (0x0A) constants SHALL reside in the shared package uart_pkg.
REQ-033 The echo buffer SHALL be a sub-module uart_pattern_fifo (parametrised depth, width 8, push/pop/full/empty).
REQ-034 Counter widths SHALL derive from parameters via $clog2; no hard-coded widths.

Verification (TICK_PERIOD=8, FIRST_CHAR=65, LAST_CHAR=67, FIFO_DEPTH=2; busy model holds tx_busy_i for 5 cycles)
REQ-035 Reset release, mode 0, 40 cycles -> tick_o every 8 cycles, first at cycle 8 after release, and tx_write_o never asserts.
REQ-036 Mode 1 for 5 ticks -> bytes 65, 66, 67, 65, 66, with one write per tick.
REQ-037 Mode 3 for 6 ticks -> bytes 65, 66, 67, 0x0D, 0x0A, 65.
REQ-038 Mode 2, push 0x31, 0x32, 0x33, 0x34 back-to-back while busy -> 0x31 and 0x32 sent, overflow_o=1, and a later mode 0 change clears overflow_o.
REQ-039 Busy model held high for 20 cycles in mode 1 -> 2 ticks coalesce into a single write of 65 after busy drops.
REQ-040 Reset pulsed during DRAIN, then mode 1 -> the next byte sent is 65 and no stale write occurs.
